// File: rtl/pipe_stage_reg.sv
// One pipeline register stage: carries an instruction, its payload words and hazard
// tags forward, with stall hold, flush-to-bubble and a per-instruction stall counter.
module pipe_stage_reg #(
   parameter int N_WORD = 2,
   parameter int W      = 32,
   parameter int A_W    = 5,
   parameter int TNEW_W = 2,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                flush,
   input  logic                valid_i,
   input  logic [W-1:0]        instr_i,
   input  logic [W-1:0]        pc8_i,
   input  logic [N_WORD*W-1:0] word_i,
   input  logic [A_W-1:0]      a3_i,
   input  logic [A_W-1:0]      a2_i,
   input  logic [TNEW_W-1:0]   tnew_i,
   output logic                valid_o,
   output logic [W-1:0]        instr_o,
   output logic [W-1:0]        pc8_o,
   output logic [N_WORD*W-1:0] word_o,
   output logic [A_W-1:0]      a3_o,
   output logic [A_W-1:0]      a2_o,
   output logic [TNEW_W-1:0]   tnew_o,
   output logic [CNT_W-1:0]    stall_cnt_o
);

   // Declaration initialisers make the power-up state match the reset state.
   logic                valid_q = 1'b0;
   logic [W-1:0]        instr_q = '0;
   logic [W-1:0]        pc8_q   = '0;
   logic [N_WORD*W-1:0] word_q  = '0;
   logic [A_W-1:0]      a3_q    = '0;
   logic [A_W-1:0]      a2_q    = '0;
   logic [TNEW_W-1:0]   tnew_q  = '0;
   logic [CNT_W-1:0]    cnt_q   = '0;

   logic [TNEW_W-1:0]   tnew_dec;

   assign tnew_dec = (tnew_i != '0) ? (tnew_i - TNEW_W'(1)) : '0;

   always_ff @(posedge clk) begin
      if (reset || flush || (en && !valid_i)) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc8_q   <= '0;
         word_q  <= '0;
         a3_q    <= '0;
         a2_q    <= '0;
         tnew_q  <= '0;
         cnt_q   <= '0;
      end else if (en) begin
         valid_q <= 1'b1;
         instr_q <= instr_i;
         pc8_q   <= pc8_i;
         word_q  <= word_i;
         a3_q    <= a3_i;
         a2_q    <= a2_i;
         tnew_q  <= tnew_dec;
         cnt_q   <= '0;
      end else if (valid_q && (cnt_q != {CNT_W{1'b1}})) begin
         // hold: only the stall counter moves, and only for a real instruction
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign valid_o     = valid_q;
   assign instr_o     = instr_q;
   assign pc8_o       = pc8_q;
   assign word_o      = word_q;
   assign a3_o        = a3_q;
   assign a2_o        = a2_q;
   assign tnew_o      = tnew_q;
   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance plus a CNT_W=2 instance
// sharing the same stimulus for counter saturation.
module tb_pipe_stage_reg;
   localparam int N_WORD = 2;
   localparam int W      = 32;
   localparam int A_W    = 5;
   localparam int TNEW_W = 2;

   logic clk = 1'b0;
   logic reset, en, flush, valid_i;
   logic [W-1:0]        instr_i, pc8_i;
   logic [N_WORD*W-1:0] word_i;
   logic [A_W-1:0]      a3_i, a2_i;
   logic [TNEW_W-1:0]   tnew_i;

   logic                valid_o, s_valid_o;
   logic [W-1:0]        instr_o, pc8_o, s_instr_o, s_pc8_o;
   logic [N_WORD*W-1:0] word_o, s_word_o;
   logic [A_W-1:0]      a3_o, a2_o, s_a3_o, s_a2_o;
   logic [TNEW_W-1:0]   tnew_o, s_tnew_o;
   logic [15:0]         stall_cnt_o;
   logic [1:0]          s_stall_cnt_o;

   int nvec = 0;
   int nerr = 0;

   wire [156:0] obs   = {valid_o, instr_o, pc8_o, word_o, a3_o, a2_o, tnew_o, stall_cnt_o};
   wire [142:0] s_obs = {s_valid_o, s_instr_o, s_pc8_o, s_word_o, s_a3_o, s_a2_o, s_tnew_o, s_stall_cnt_o};

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
      .instr_i(instr_i), .pc8_i(pc8_i), .word_i(word_i), .a3_i(a3_i), .a2_i(a2_i),
      .tnew_i(tnew_i), .valid_o(valid_o), .instr_o(instr_o), .pc8_o(pc8_o),
      .word_o(word_o), .a3_o(a3_o), .a2_o(a2_o), .tnew_o(tnew_o),
      .stall_cnt_o(stall_cnt_o)
   );

   pipe_stage_reg #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
      .instr_i(instr_i), .pc8_i(pc8_i), .word_i(word_i), .a3_i(a3_i), .a2_i(a2_i),
      .tnew_i(tnew_i), .valid_o(s_valid_o), .instr_o(s_instr_o), .pc8_o(s_pc8_o),
      .word_o(s_word_o), .a3_o(s_a3_o), .a2_o(s_a2_o), .tnew_o(s_tnew_o),
      .stall_cnt_o(s_stall_cnt_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ref_load();
      en = 1'b1; flush = 1'b0; valid_i = 1'b1;
      instr_i = 32'h8C220004; pc8_i = 32'h00003008;
      word_i = {32'h12345678, 32'h0000ABCD};
      a3_i = 5'd2; a2_i = 5'd2; tnew_i = 2'd2;
   endtask

   task automatic test_reset();
      #1;
      nvec++;
      if (obs !== 157'd0) begin
         nerr++; $display("FAIL powerup: got %h want 0", obs);
      end
      reset = 1'b1; en = 1'b1; flush = 1'b0; valid_i = 1'b1;
      instr_i = 32'hFFFFFFFF; pc8_i = 32'hFFFFFFFF; word_i = '1;
      a3_i = '1; a2_i = '1; tnew_i = '1;
      step();
      nvec++;
      if (obs !== 157'd0) begin
         nerr++; $display("FAIL reset: got %h want 0", obs);
      end
      reset = 1'b0;
   endtask

   task automatic test_load();
      drive_ref_load();
      step();
      nvec++;
      if (obs !== {1'b1, 32'h8C220004, 32'h00003008, 64'h12345678_0000ABCD, 5'd2, 5'd2, 2'd1, 16'd0}) begin
         nerr++; $display("FAIL load: got %h", obs);
      end
      nvec++;
      if (word_o[31:0] !== 32'h0000ABCD || word_o[63:32] !== 32'h12345678) begin
         nerr++; $display("FAIL word_order: got %h want 123456780000abcd", word_o);
      end
   endtask

   task automatic test_tnew_sat();
      drive_ref_load(); tnew_i = 2'd0;
      step();
      nvec++;
      if (tnew_o !== 2'd0) begin
         nerr++; $display("FAIL tnew0: got %0d want 0", tnew_o);
      end
      tnew_i = 2'd3;
      step();
      nvec++;
      if (tnew_o !== 2'd2) begin
         nerr++; $display("FAIL tnew3: got %0d want 2", tnew_o);
      end
      tnew_i = 2'd1;
      step();
      nvec++;
      if (tnew_o !== 2'd0) begin
         nerr++; $display("FAIL tnew1: got %0d want 0", tnew_o);
      end
   endtask

   task automatic test_stall();
      drive_ref_load();
      step();
      en = 1'b0;
      instr_i = 32'hDEADBEEF; pc8_i = 32'h1; word_i = 64'h5; a3_i = 5'd9; a2_i = 5'd7; tnew_i = 2'd3;
      for (int i = 1; i <= 5; i++) begin
         step();
         nvec++;
         if (obs !== {1'b1, 32'h8C220004, 32'h00003008, 64'h12345678_0000ABCD, 5'd2, 5'd2, 2'd1, 16'(i)}) begin
            nerr++; $display("FAIL stall_%0d: got %h want cnt %0d held data", i, obs, i);
         end
      end
      en = 1'b1;
      step();
      nvec++;
      if (obs !== {1'b1, 32'hDEADBEEF, 32'h00000001, 64'h5, 5'd9, 5'd7, 2'd2, 16'd0}) begin
         nerr++; $display("FAIL stall_release: got %h", obs);
      end
   endtask

   task automatic test_bubble_load();
      drive_ref_load();
      step();
      valid_i = 1'b0;
      step();
      nvec++;
      if (obs !== 157'd0) begin
         nerr++; $display("FAIL bubble_load: got %h want 0", obs);
      end
      en = 1'b0;
      step();
      nvec++;
      if (stall_cnt_o !== 16'd0 || valid_o !== 1'b0) begin
         nerr++; $display("FAIL bubble_hold: cnt %0d valid %b want 0 0", stall_cnt_o, valid_o);
      end
   endtask

   task automatic test_flush();
      drive_ref_load();
      step();
      en = 1'b0;
      step(); step();
      flush = 1'b1;
      step();
      nvec++;
      if (obs !== 157'd0) begin
         nerr++; $display("FAIL flush: got %h want 0", obs);
      end
      flush = 1'b0;
      step(); step();
      nvec++;
      if (obs !== 157'd0) begin
         nerr++; $display("FAIL flush_hold: got %h want 0", obs);
      end
      en = 1'b1; flush = 1'b1; valid_i = 1'b1;
      step();
      nvec++;
      if (obs !== 157'd0) begin
         nerr++; $display("FAIL flush_over_load: got %h want 0", obs);
      end
      flush = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      drive_ref_load();
      step();
      en = 1'b0;
      step(); step(); step();
      nvec++;
      if (stall_cnt_o !== 16'd3) begin
         nerr++; $display("FAIL pre_reset_cnt: got %0d want 3", stall_cnt_o);
      end
      reset = 1'b1; flush = 1'b1; en = 1'b1;
      step();
      nvec++;
      if (obs !== 157'd0 || s_obs !== 143'd0) begin
         nerr++; $display("FAIL reset_mid_stall: got %h / %h want 0", obs, s_obs);
      end
      reset = 1'b0; flush = 1'b0; en = 1'b0;
      step();
      nvec++;
      if (obs !== 157'd0) begin
         nerr++; $display("FAIL post_reset_hold: got %h want 0", obs);
      end
      drive_ref_load(); a3_i = 5'd31; tnew_i = 2'd3;
      step();
      nvec++;
      if (obs !== {1'b1, 32'h8C220004, 32'h00003008, 64'h12345678_0000ABCD, 5'd31, 5'd2, 2'd2, 16'd0}) begin
         nerr++; $display("FAIL post_reset_load: got %h", obs);
      end
   endtask

   task automatic test_cnt_sat();
      logic [1:0] exp_s [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      drive_ref_load();
      step();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         nvec++;
         if (s_stall_cnt_o !== exp_s[i] || stall_cnt_o !== 16'(i + 1) || s_tnew_o !== 2'd1) begin
            nerr++;
            $display("FAIL cnt_sat_%0d: got %0d/%0d tnew %0d want %0d/%0d tnew 1",
                     i, s_stall_cnt_o, stall_cnt_o, s_tnew_o, exp_s[i], i + 1);
         end
      end
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; flush = 1'b0; valid_i = 1'b0;
      instr_i = '0; pc8_i = '0; word_i = '0; a3_i = '0; a2_i = '0; tnew_i = '0;
      test_reset();
      test_load();
      test_tnew_sat();
      test_stall();
      test_bubble_load();
      test_flush();
      test_reset_mid_stall();
      test_cnt_sat();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, want completion");
      $fatal(1);
   end

endmodule
